sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 32 +++
 rtl/sram_arb_rr2.sv | 25 ++
 rtl/sram_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional feature macro: SRAM_ARB_TIMEOUT_EN (enables the WAIT_DONE watchdog).
package sram_arb_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RESP      = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_t;

  // Requester identities.
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_UART = 1'b1;

  // Default timing constants in clk cycles.
  localparam int DEFAULT_GAP_CYCLES     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Rising edge of a level signal given its registered previous value.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin picker. When both ports request, the port that was
// not granted last wins; a lone requester always wins.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  // Pick the winner from the request pair and the last-grant pointer.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = (last == PORT_CPU) ? PORT_UART : PORT_CPU;
    end else if (req1) begin
      grant_id = PORT_UART;
    end else begin
      grant_id = PORT_CPU;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single 32-bit SRAM word controller.
// Port 0 is the CPU data port, port 1 the UART loader. One access at a time:
// latch request, issue, wait for the matching done edge, ack, then hold
// enable low for GAP_CYCLES so the controller settles back to idle.
// Optional feature macro: SRAM_ARB_TIMEOUT_EN -- when defined, a watchdog in
// WAIT_DONE ends a stuck access with err=1 after TIMEOUT_CYCLES.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              sram_enable,
  output logic              sram_writenable,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_write,
  input  logic [DATA_W-1:0] sram_data_read,
  input  logic              sram_read_done,
  input  logic              sram_write_done
);

  // One counter serves both the GAP countdown and the WAIT_DONE watchdog
  // (the states are disjoint), so it is sized for the larger of the two.
  localparam int CNT_MAX = max_int(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  arb_state_t        state;
  arb_state_t        state_next;

  logic              grant_valid;
  logic              grant_id;
  logic              last_grant;

  logic              gnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic              rd_prev;
  logic              wr_prev;
  logic              done_edge;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt;

  logic              enable_next;
  logic              ack0_next;
  logic              ack1_next;
  logic              err_next;
  logic              rdata_load;
  logic [DATA_W-1:0] rdata_next;

  sram_arb_rr2 u_rr2 (
    .req0        (req0),
    .req1        (req1),
    .last        (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Rising edge of the done line that matches the latched access direction.
  always_comb begin
    if (we_r) begin
      done_edge = rise_edge(sram_write_done, wr_prev);
    end else begin
      done_edge = rise_edge(sram_read_done, rd_prev);
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  // Watchdog fires in the cycle whose increment would bring cnt to TIMEOUT_CYCLES.
  always_comb begin
    if (state == ST_WAIT_DONE) begin
      timeout_hit = (cnt == TO_LAST);
    end else begin
      timeout_hit = 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_edge || timeout_hit) begin
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_RESP: begin
        state_next = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_GAP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered controller and response outputs.
  always_comb begin
    enable_next = 1'b0;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    err_next    = 1'b0;
    rdata_load  = 1'b0;
    rdata_next  = sram_data_read;
    case (state)
      ST_ISSUE: begin
        enable_next = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (done_edge || timeout_hit) begin
          enable_next = 1'b0;
          ack0_next   = (gnt_r == PORT_CPU);
          ack1_next   = (gnt_r == PORT_UART);
          // A real done edge wins over a watchdog expiry in the same cycle.
          err_next    = ~done_edge;
          rdata_load  = ~we_r;
          rdata_next  = done_edge ? sram_data_read : '0;
        end else begin
          enable_next = 1'b1;
        end
      end
      ST_IDLE, ST_RESP, ST_GAP: begin
        enable_next = 1'b0;
      end
      default: begin
        enable_next = 1'b0;
      end
    endcase
  end

  // Registered outputs, request latches, edge history, pointer and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      err0            <= 1'b0;
      err1            <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
      busy            <= 1'b0;
      sram_enable     <= 1'b0;
      sram_writenable <= 1'b0;
      sram_address    <= '0;
      sram_data_write <= '0;
      gnt_r           <= PORT_CPU;
      we_r            <= 1'b0;
      addr_r          <= '0;
      wdata_r         <= '0;
      rd_prev         <= 1'b0;
      wr_prev         <= 1'b0;
      last_grant      <= PORT_UART;
      cnt             <= '0;
    end else begin
      ack0        <= ack0_next;
      ack1        <= ack1_next;
      err0        <= ack0_next & err_next;
      err1        <= ack1_next & err_next;
      busy        <= (state_next != ST_IDLE);
      sram_enable <= enable_next;
      rd_prev     <= sram_read_done;
      wr_prev     <= sram_write_done;

      if (rdata_load) begin
        if (gnt_r == PORT_UART) begin
          rdata1 <= rdata_next;
        end else begin
          rdata0 <= rdata_next;
        end
      end

      // Capture the winning request; inputs may change once it is acked.
      if ((state == ST_IDLE) && grant_valid) begin
        gnt_r <= grant_id;
        if (grant_id == PORT_UART) begin
          we_r    <= we1;
          addr_r  <= addr1;
          wdata_r <= wdata1;
        end else begin
          we_r    <= we0;
          addr_r  <= addr0;
          wdata_r <= wdata0;
        end
      end

      // Controller bus is loaded once and then held through WAIT_DONE.
      if (state == ST_ISSUE) begin
        sram_writenable <= we_r;
        sram_address    <= addr_r;
        sram_data_write <= wdata_r;
      end

      if (state == ST_RESP) begin
        last_grant <= gnt_r;
      end

      case (state)
        ST_RESP: begin
          cnt <= GAP_LOAD;
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_WAIT_DONE: begin
`ifdef SRAM_ARB_TIMEOUT_EN
          cnt <= cnt + CNT_ONE;
`else
          cnt <= '0;
`endif
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a table of single accesses plus
// hand-written contention, stuck-done, mid-access reset and timeout sequences.
module tb_sram_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int GAP    = 16;
  localparam int TMO    = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, err0, ack1, err1, busy;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sram_enable, sram_writenable;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_data_write, sram_data_read;
  logic              sram_read_done, sram_write_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .busy(busy),
    .sram_enable(sram_enable), .sram_writenable(sram_writenable),
    .sram_address(sram_address), .sram_data_write(sram_data_write),
    .sram_data_read(sram_data_read),
    .sram_read_done(sram_read_done), .sram_write_done(sram_write_done)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    int          delay;
    logic [31:0] exp_rdata0;
    logic [31:0] exp_rdata1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [15:0] a, input logic [31:0] d);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  function automatic logic ack_of(input logic port);
    return port ? ack1 : ack0;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_enable(input int budget, input string tag);
    int n = 0;
    while (!sram_enable && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_enable_seen"}, {31'd0, sram_enable}, 32'd1);
  endtask

  // Read completion for a granted port: done edge, then check ack and rdata.
  task automatic serve_read(input logic [31:0] d, input logic port, input string tag);
    sram_data_read = d;
    sram_read_done = 1'b1;
    @(negedge clk);
    check({tag, "_ack"}, {31'd0, ack_of(port)}, 32'd1);
    check({tag, "_ack_other"}, {31'd0, ack_of(~port)}, 32'd0);
    check({tag, "_rdata"}, port ? rdata1 : rdata0, d);
    drop_req(port);
    sram_read_done = 1'b0;
  endtask

  // One complete access from IDLE, checking latency, bus values, hold window and response.
  task automatic run_access(input vec_t v, input string tag);
    logic bad;
    wait_idle(40, tag);
    @(negedge clk);
    drive_req(v.port, v.we, v.addr, v.wdata);
    @(negedge clk);
    check({tag, "_en_not_early"}, {31'd0, sram_enable}, 32'd0);
    @(negedge clk);
    check({tag, "_en_latency"}, {31'd0, sram_enable}, 32'd1);
    check({tag, "_addr"}, {16'd0, sram_address}, {16'd0, v.addr});
    check({tag, "_we"}, {31'd0, sram_writenable}, {31'd0, v.we});
    check({tag, "_wdata"}, sram_data_write, v.wdata);
    bad = 1'b0;
    // During a write the non-matching read_done toggles and must be ignored.
    if (v.we) sram_read_done = 1'b1;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      if (!sram_enable || ack0 || ack1 || sram_address != v.addr) bad = 1'b1;
    end
    check({tag, "_hold_window"}, {31'd0, bad}, 32'd0);
    sram_read_done = 1'b0;
    sram_data_read = v.rd_data;
    if (v.we) sram_write_done = 1'b1;
    else      sram_read_done  = 1'b1;
    @(negedge clk);
    check({tag, "_ack"}, {31'd0, ack_of(v.port)}, 32'd1);
    check({tag, "_ack_other"}, {31'd0, ack_of(~v.port)}, 32'd0);
    check({tag, "_en_drop"}, {31'd0, sram_enable}, 32'd0);
    check({tag, "_err"}, {30'd0, err0, err1}, 32'd0);
    check({tag, "_rdata0"}, rdata0, v.exp_rdata0);
    check({tag, "_rdata1"}, rdata1, v.exp_rdata1);
    drop_req(v.port);
    sram_data_read = 32'h0BAD_0BAD;
    @(negedge clk);
    check({tag, "_ack_pulse"}, {30'd0, ack0, ack1}, 32'd0);
    // Done stays high a little longer, as a level.
    @(negedge clk);
    sram_read_done  = 1'b0;
    sram_write_done = 1'b0;
    check({tag, "_rdata0_hold"}, rdata0, v.exp_rdata0);
    check({tag, "_rdata1_hold"}, rdata1, v.exp_rdata1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic bad;
    vec_t pv;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    sram_data_read = '0; sram_read_done = 1'b0; sram_write_done = 1'b0;

    //             port  we    addr      wdata         rd_data       dly exp_rdata0    exp_rdata1
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0000_0000, 32'hDEAD_BEEF, 40, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 32'h1234_5678, 32'h0BAD_F00D,  5, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0300, 32'h0000_1111, 32'hCAFE_F00D,  3, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 16'h0011, 32'hA5A5_A5A5, 32'h55AA_55AA,  7, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h7777_7777,  1, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 32'h0000_2222, 32'h0000_0001,  0, 32'h0000_0001, 32'hCAFE_F00D};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ack",   {28'd0, ack0, ack1, err0, err1}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_en",    {30'd0, sram_enable, sram_writenable}, 32'd0);
    check("reset_addr",  {16'd0, sram_address}, 32'd0);
    check("reset_wdata", sram_data_write, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_rdata1", rdata1, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i], $sformatf("v%0d", i));
    end

    // Contention from reset: port 0 first, then port 1, gap enforced between.
    pulse_reset();
    drive_req(1'b0, 1'b0, 16'h0040, 32'h0);
    drive_req(1'b1, 1'b0, 16'h0050, 32'h0);
    wait_enable(10, "cont1");
    check("cont1_addr", {16'd0, sram_address}, 32'h0000_0040);
    serve_read(32'h1111_1111, 1'b0, "cont1");
    n = 0;
    while (!sram_enable && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("cont_gap_len", {31'd0, (n >= GAP)}, 32'd1);
    wait_enable(2, "cont2");
    check("cont2_addr", {16'd0, sram_address}, 32'h0000_0050);
    serve_read(32'h2222_2222, 1'b1, "cont2");
    check("cont2_rdata0_held", rdata0, 32'h1111_1111);
    wait_idle(40, "cont3");
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0060, 32'h0);
    drive_req(1'b1, 1'b0, 16'h0070, 32'h0);
    wait_enable(10, "cont3");
    check("cont3_addr", {16'd0, sram_address}, 32'h0000_0060);
    serve_read(32'h3333_3333, 1'b0, "cont3");
    wait_enable(40, "cont4");
    check("cont4_addr", {16'd0, sram_address}, 32'h0000_0070);
    serve_read(32'h4444_4444, 1'b1, "cont4");

    // Stuck read_done: second access must wait for a fresh rising edge.
    wait_idle(40, "stuck1");
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0080, 32'h0);
    wait_enable(10, "stuck1");
    sram_data_read = 32'h5555_5555;
    sram_read_done = 1'b1;
    @(negedge clk);
    check("stuck1_ack", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    wait_idle(40, "stuck2");
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h0090, 32'h0);
    wait_enable(10, "stuck2");
    sram_data_read = 32'h6666_6666;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack0 || ack1 || !sram_enable) bad = 1'b1;
    end
    check("stuck2_no_early_ack", {31'd0, bad}, 32'd0);
    sram_read_done = 1'b0;
    @(negedge clk);
    sram_read_done = 1'b1;
    @(negedge clk);
    check("stuck2_ack", {31'd0, ack0}, 32'd1);
    check("stuck2_rdata0", rdata0, 32'h6666_6666);
    req0 = 1'b0;
    sram_read_done = 1'b0;

    // Reset in the middle of WAIT_DONE abandons the access without an ack.
    wait_idle(40, "rstmid");
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h00B0, 32'h0);
    wait_enable(10, "rstmid");
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_enable", {31'd0, sram_enable}, 32'd0);
    check("rstmid_busy",   {31'd0, busy}, 32'd0);
    check("rstmid_ack",    {30'd0, ack0, ack1}, 32'd0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack0 || ack1 || sram_enable) bad = 1'b1;
    end
    check("rstmid_quiet", {31'd0, bad}, 32'd0);
    pv = '{1'b0, 1'b0, 16'h00C0, 32'h0, 32'h600D_CAFE, 4, 32'h600D_CAFE, 32'h0000_0000};
    run_access(pv, "post_rst");

`ifdef SRAM_ARB_TIMEOUT_EN
    // No done at all: watchdog acks with err=1 and zero read data.
    wait_idle(40, "tmo");
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'h00D0, 32'h0);
    wait_enable(10, "tmo");
    n = 0;
    while (!ack0 && n < TMO + 10) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_ack",    {31'd0, ack0}, 32'd1);
    check("tmo_err0",   {31'd0, err0}, 32'd1);
    check("tmo_rdata0", rdata0, 32'd0);
    check("tmo_enable", {31'd0, sram_enable}, 32'd0);
    req0 = 1'b0;
    wait_idle(40, "tmo_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
